// File: rtl/alu_operand_sequencer.sv
// Operand entry and ALU issue controller: builds hex operands from key events, issues
// one start pulse, waits for done and holds the result. Optional timeout: ALU_SEQ_TIMEOUT_EN.
module alu_operand_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_pressed,
    input  logic [3:0]       key_code,
    input  logic             btn_enter,
    input  logic             btn_clear,
    input  logic [3:0]       sw_op,
    input  logic             alu_done,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [3:0]       opcode,
    output logic             alu_start,
    output logic             result_valid,
    output logic [2:0]       state,
    output logic             err
);

    localparam int unsigned DIGITS = WIDTH / 4;
    localparam int unsigned CntW   = $clog2(DIGITS + 1);
    localparam logic [CntW-1:0] DigitsC = CntW'(DIGITS);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_SHOW = 3'd4;

    if (WIDTH < 4 || (WIDTH % 4) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("alu_operand_sequencer: illegal WIDTH/TIMEOUT");
    end

    logic             key_sync1_q, key_sync2_q, key_prev_q;
    logic             ent_prev_q, clr_prev_q;
    logic             key_ev, ent_ev, clr_ev;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [CntW-1:0]  count_q, count_d;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    // key_pressed is asynchronous: two sync flops, then a third for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            key_sync1_q <= 1'b0;
            key_sync2_q <= 1'b0;
            key_prev_q  <= 1'b0;
            ent_prev_q  <= 1'b0;
            clr_prev_q  <= 1'b0;
        end else begin
            key_sync1_q <= key_pressed;
            key_sync2_q <= key_sync1_q;
            key_prev_q  <= key_sync2_q;
            ent_prev_q  <= btn_enter;
            clr_prev_q  <= btn_clear;
        end
    end

    assign key_ev = key_sync2_q & ~key_prev_q;
    assign ent_ev = btn_enter & ~ent_prev_q;
    assign clr_ev = btn_clear & ~clr_prev_q;

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        opcode_d = opcode_q;
        count_d  = count_q;
`ifdef ALU_SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        if (state_q > S_SHOW) begin
            // Illegal encoding: behave exactly as a reset
            state_d  = S_A;
            op_a_d   = '0;
            op_b_d   = '0;
            opcode_d = '0;
            count_d  = '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            tmo_d    = '0;
            err_d    = 1'b0;
`endif
        end else if (clr_ev) begin
            state_d = S_A;
            op_a_d  = '0;
            op_b_d  = '0;
            count_d = '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                S_A: begin
                    if (ent_ev) begin
                        state_d = S_B;
                        count_d = '0;
                    end else if (key_ev && count_q < DigitsC) begin
                        op_a_d  = (op_a_q << 4) | WIDTH'(key_code);
                        count_d = count_q + 1'b1;
                    end
                end
                S_B: begin
                    if (ent_ev) begin
                        state_d  = S_EXEC;
                        opcode_d = sw_op;
                    end else if (key_ev && count_q < DigitsC) begin
                        op_b_d  = (op_b_q << 4) | WIDTH'(key_code);
                        count_d = count_q + 1'b1;
                    end
                end
                S_EXEC: begin
                    state_d = S_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
                S_WAIT: begin
                    if (alu_done) begin
                        state_d = S_SHOW;
`ifdef ALU_SEQ_TIMEOUT_EN
                        err_d   = 1'b0;
                    end else if (tmo_q == TmoLast) begin
                        state_d = S_SHOW;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d   = tmo_q + 1'b1;
`endif
                    end
                end
                S_SHOW: begin
                    if (ent_ev) begin
                        state_d = S_A;
                        op_a_d  = '0;
                        op_b_d  = '0;
                        count_d = '0;
`ifdef ALU_SEQ_TIMEOUT_EN
                        err_d   = 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign opcode       = opcode_q;
    assign state        = state_q;
    assign alu_start    = (state_q == S_EXEC);
    assign result_valid = (state_q == S_SHOW);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer (WIDTH=8, TIMEOUT=16).
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_pressed;
    logic [3:0] key_code;
    logic       btn_enter;
    logic       btn_clear;
    logic [3:0] sw_op;
    logic       alu_done;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] opcode;
    logic       alu_start;
    logic       result_valid;
    logic [2:0] state;
    logic       err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int start_ref;

    alu_operand_sequencer #(
        .WIDTH   (8),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_pressed  (key_pressed),
        .key_code     (key_code),
        .btn_enter    (btn_enter),
        .btn_clear    (btn_clear),
        .sw_op        (sw_op),
        .alu_done     (alu_done),
        .op_a         (op_a),
        .op_b         (op_b),
        .opcode       (opcode),
        .alu_start    (alu_start),
        .result_valid (result_valid),
        .state        (state),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (alu_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_key(input logic [3:0] code);
        key_code    = code;
        key_pressed = 1'b1;
        repeat (4) tick();
        key_pressed = 1'b0;
        repeat (3) tick();
    endtask

    task automatic press_enter();
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
        tick();
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_pressed = 1'b0; key_code = 4'h0; btn_enter = 1'b0;
        btn_clear = 1'b0; sw_op = 4'h0; alu_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_state", 32'(state), 32'd0);
        check("reset_op_a", 32'(op_a), 32'h00);
        check("reset_op_b", 32'(op_b), 32'h00);
        check("reset_opcode", 32'(opcode), 32'h0);
        check("reset_start", 32'(alu_start), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // 1: A=3C, B=05, opcode 2
        press_key(4'h3);
        press_key(4'hC);
        check("t1_op_a", 32'(op_a), 32'h3C);
        press_enter();
        check("t1_state_b", 32'(state), 32'd1);
        press_key(4'h0);
        press_key(4'h5);
        check("t1_op_b", 32'(op_b), 32'h05);
        sw_op = 4'h2;
        start_ref = start_cnt;
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
        check("t1_state_exec", 32'(state), 32'd2);
        check("t1_start_hi", 32'(alu_start), 32'd1);
        check("t1_opcode", 32'(opcode), 32'h2);
        tick();
        check("t1_state_wait", 32'(state), 32'd3);
        check("t1_start_lo", 32'(alu_start), 32'd0);
        check("t1_start_count", 32'(start_cnt - start_ref), 32'd1);

        // 3: done four cycles after start
        repeat (2) tick();
        check("t3_still_wait", 32'(state), 32'd3);
        check("t3_valid_lo", 32'(result_valid), 32'd0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("t3_state_show", 32'(state), 32'd4);
        check("t3_valid_hi", 32'(result_valid), 32'd1);
        check("t3_hold_op_a", 32'(op_a), 32'h3C);
        check("t3_hold_op_b", 32'(op_b), 32'h05);
        press_key(4'h9);
        check("t3_key_ignored", 32'(op_a), 32'h3C);
        press_enter();
        check("t3_state_a", 32'(state), 32'd0);
        check("t3_op_a_clr", 32'(op_a), 32'h00);
        check("t3_op_b_clr", 32'(op_b), 32'h00);
        check("t3_valid_clr", 32'(result_valid), 32'd0);

        // 2: digit saturation
        press_key(4'h1);
        press_key(4'h2);
        press_key(4'h3);
        check("t2_op_a_sat", 32'(op_a), 32'h12);
        press_enter();
        press_key(4'h7);
        press_key(4'h7);
        press_key(4'h7);
        check("t2_op_b_sat", 32'(op_b), 32'h77);
        press_clear();
        check("t2_clr_state", 32'(state), 32'd0);
        check("t2_clr_op_a", 32'(op_a), 32'h00);
        check("t2_clr_op_b", 32'(op_b), 32'h00);

        // 4: enter beats key in the same cycle; clear beats enter
        press_key(4'h4);
        check("t4_op_a_pre", 32'(op_a), 32'h04);
        key_code = 4'h9;
        key_pressed = 1'b1;
        repeat (2) tick();
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
        key_pressed = 1'b0;
        repeat (4) tick();
        check("t4_state_b", 32'(state), 32'd1);
        check("t4_op_a_kept", 32'(op_a), 32'h04);
        check("t4_op_b_kept", 32'(op_b), 32'h00);
        press_key(4'h6);
        check("t4_op_b", 32'(op_b), 32'h06);
        btn_clear = 1'b1;
        btn_enter = 1'b1;
        tick();
        btn_clear = 1'b0;
        btn_enter = 1'b0;
        tick();
        check("t4_clr_state", 32'(state), 32'd0);
        check("t4_clr_op_a", 32'(op_a), 32'h00);
        check("t4_clr_op_b", 32'(op_b), 32'h00);

        // 5: clear during wait, late done is ignored
        press_key(4'h1);
        press_enter();
        press_key(4'h2);
        sw_op = 4'h3;
        press_enter();
        check("t5_state_wait", 32'(state), 32'd3);
        press_clear();
        check("t5_clr_state", 32'(state), 32'd0);
        start_ref = start_cnt;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        repeat (3) tick();
        check("t5_state_a", 32'(state), 32'd0);
        check("t5_valid_lo", 32'(result_valid), 32'd0);
        check("t5_no_start", 32'(start_cnt - start_ref), 32'd0);

        // 6: zero-digit operands, then wait without done
        press_enter();
        press_enter();
        check("t6_state_wait", 32'(state), 32'd3);
        check("t6_op_a_zero", 32'(op_a), 32'h00);
        repeat (15) tick();
        check("t6_wait_15", 32'(state), 32'd3);
        tick();
`ifdef ALU_SEQ_TIMEOUT_EN
        check("t6_tmo_state", 32'(state), 32'd4);
        check("t6_tmo_err", 32'(err), 32'd1);
        check("t6_tmo_valid", 32'(result_valid), 32'd1);
        press_enter();
        check("t6_err_cleared", 32'(err), 32'd0);
        check("t6_back_a", 32'(state), 32'd0);
        // done on the final timeout cycle wins
        press_enter();
        press_enter();
        repeat (15) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("t6_done_wins_state", 32'(state), 32'd4);
        check("t6_done_wins_err", 32'(err), 32'd0);
`else
        check("t6_no_tmo_state", 32'(state), 32'd3);
        check("t6_no_tmo_err", 32'(err), 32'd0);
        repeat (20) tick();
        check("t6_still_wait", 32'(state), 32'd3);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("t6_done_state", 32'(state), 32'd4);
        check("t6_done_err", 32'(err), 32'd0);
`endif
        press_enter();
        check("t6_final_state", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
